activation_unit: RTL and testbench

ACTIVATION_UNIT -- requirements
Module: activation_unit

---
 rtl/activation_unit.sv | 132 +++++++++++++
 tb/tb_activation_unit.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/activation_unit.sv
// Two-stage elementwise activation pipeline (bypass / ReLU / leaky / clipped ReLU)
// with a saturating count of output elements forced to zero.

module act_lane #(
  parameter int W          = 16,
  parameter int LEAK_SHIFT = 3
) (
  input  logic [W-1:0] x,
  input  logic [1:0]   mode,
  input  logic [W-1:0] clip,
  output logic [W-1:0] y,
  output logic         zero
);
  logic neg;
  assign neg = x[W-1];

  always_comb begin
    y    = x;
    zero = 1'b0;
    case (mode)
      2'b01: if (neg) begin
        y    = '0;
        zero = 1'b1;
      end
      2'b10: if (neg) y = $signed(x) >>> LEAK_SHIFT;
      2'b11: begin
        // A negative ceiling zeroes everything, but a zero input is never "forced".
        if (clip[W-1] || neg) begin
          y    = '0;
          zero = (x != '0);
        end else if ($signed(x) > $signed(clip)) begin
          y = clip;
        end
      end
      default: ;
    endcase
  end
endmodule

module activation_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 4,
  parameter int LEAK_SHIFT = 3,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [1:0]                     in_mode,
  input  logic [DATA_WIDTH-1:0]          clip_val,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  input  logic                           clr_stats,
  output logic [CNT_WIDTH-1:0]           zero_cnt
);
  localparam int STAGES = 2;
  localparam int ZW     = $clog2(CHANNELS + 1);

  typedef logic [CHANNELS-1:0][DATA_WIDTH-1:0] vec_t;
  typedef struct packed {
    vec_t                  data;
    logic [1:0]            mode;
    logic [DATA_WIDTH-1:0] clip;
  } req_t;
  typedef struct packed {
    vec_t          data;
    logic [ZW-1:0] zeros;
  } rsp_t;

  logic [STAGES:1]    vld_pipe;
  req_t               s1;
  rsp_t               s2;
  vec_t               lane_y;
  logic [CHANNELS-1:0] lane_zero;
  logic [ZW-1:0]      zsum;
  logic               stall;
  logic               hs;
  logic [CNT_WIDTH:0] cnt_sum;

  assign out_valid = vld_pipe[STAGES];
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  assign hs        = out_valid && out_ready;
  assign out_data  = s2.data;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    act_lane #(.W(DATA_WIDTH), .LEAK_SHIFT(LEAK_SHIFT)) u_lane (
      .x    (s1.data[i]),
      .mode (s1.mode),
      .clip (s1.clip),
      .y    (lane_y[i]),
      .zero (lane_zero[i])
    );
  end

  always_comb begin
    zsum = '0;
    for (int i = 0; i < CHANNELS; i++) zsum = zsum + ZW'(lane_zero[i]);
  end

  // One extra bit catches the wrap so the counter can pin at all-ones.
  assign cnt_sum = {1'b0, zero_cnt} + (CNT_WIDTH+1)'(s2.zeros);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
      zero_cnt <= '0;
    end else begin
      if (!stall) begin
        vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
        if (in_valid) begin
          s1.data <= in_data;
          s1.mode <= in_mode;
          s1.clip <= clip_val;
        end
        if (vld_pipe[1]) begin
          s2.data  <= lane_y;
          s2.zeros <= zsum;
        end
      end
      if (clr_stats)
        zero_cnt <= '0;
      else if (hs)
        zero_cnt <= cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_activation_unit.sv
// Randomized and directed bench for activation_unit against an integer-arithmetic
// reference model; a second instance with a narrow counter exercises saturation.

module tb_activation_unit;
  localparam int DW = 16, CH = 4, LS = 3, CW = 32, SCW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, in_valid, out_ready, clr_stats;
  logic [1:0]          in_mode;
  logic [CH*DW-1:0]    in_data;
  logic [DW-1:0]       clip_val;
  logic                in_ready, out_valid;
  logic [CH*DW-1:0]    out_data;
  logic [CW-1:0]       zero_cnt;
  logic                s_in_ready, s_out_valid;
  logic [CH*DW-1:0]    s_out_data;
  logic [SCW-1:0]      s_zero_cnt;

  int checks = 0, errors = 0;
  int exp_cnt = 0;
  logic [CH*DW-1:0] q_data[$];
  int               q_z[$];

  activation_unit #(.DATA_WIDTH(DW), .CHANNELS(CH), .LEAK_SHIFT(LS), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .clip_val(clip_val), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .clr_stats(clr_stats), .zero_cnt(zero_cnt));

  activation_unit #(.DATA_WIDTH(DW), .CHANNELS(CH), .LEAK_SHIFT(LS), .CNT_WIDTH(SCW)) u_sat (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_mode(in_mode), .clip_val(clip_val), .out_data(s_out_data), .out_valid(s_out_valid),
    .out_ready(out_ready), .clr_stats(clr_stats), .zero_cnt(s_zero_cnt));

  // Reference model: plain signed integer arithmetic, floor division for leaky.
  function automatic int ref_y(int x, int m, int c);
    case (m)
      1: return (x < 0) ? 0 : x;
      2: return (x >= 0) ? x : (x - (2**LS - 1)) / (2**LS);
      3: if (c < 0 || x < 0) return 0; else return (x > c) ? c : x;
      default: return x;
    endcase
  endfunction

  function automatic bit ref_z(int x, int m, int c);
    return (m == 1 && x < 0) || (m == 3 && x != 0 && (x < 0 || c < 0));
  endfunction

  function automatic logic [CH*DW-1:0] ref_beat(logic [CH*DW-1:0] d, logic [1:0] m, logic [DW-1:0] c);
    logic [CH*DW-1:0] r;
    logic [DW-1:0] e;
    int y;
    r = '0;
    for (int i = 0; i < CH; i++) begin
      e = d[i*DW +: DW];
      y = ref_y(int'($signed(e)), int'(m), int'($signed(c)));
      r[i*DW +: DW] = y[DW-1:0];
    end
    return r;
  endfunction

  function automatic int ref_zeros(logic [CH*DW-1:0] d, logic [1:0] m, logic [DW-1:0] c);
    int n;
    logic [DW-1:0] e;
    n = 0;
    for (int i = 0; i < CH; i++) begin
      e = d[i*DW +: DW];
      n += int'(ref_z(int'($signed(e)), int'(m), int'($signed(c))));
    end
    return n;
  endfunction

  function automatic logic [CH*DW-1:0] pack4(int a, int b, int c, int d);
    return {DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  function automatic logic [DW-1:0] rand_elem();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h8000;
      2: return 16'h7FFF;
      3: return 16'hFFFF;
      4: return 16'h0001;
      default: return DW'($urandom);
    endcase
  endfunction

  function automatic logic [CH*DW-1:0] rand_beat();
    logic [CH*DW-1:0] r;
    for (int i = 0; i < CH; i++) r[i*DW +: DW] = rand_elem();
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_clip();
    case ($urandom_range(0, 3))
      0: return 16'hFFFD;
      1: return 16'h0000;
      2: return 16'd100;
      default: return DW'($urandom);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic send_beat(logic [CH*DW-1:0] d, logic [1:0] m, logic [DW-1:0] c);
    in_valid = 1'b1; in_data = d; in_mode = m; clip_val = c;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = rand_beat(); in_mode = 2'b01;
    out_ready = 1'b1; clr_stats = 1'b0; clip_val = 16'd50;
    repeat (3) tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    settle();
    exp_cnt = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    checks++; if (zero_cnt !== '0) begin errors++; $display("FAIL reset_zero_cnt: got %0d expected 0", zero_cnt); end
    checks++; if (in_ready !== 1'b1 || s_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b/%b expected 1", in_ready, s_in_ready); end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_relu();
    logic [CH*DW-1:0] e;
    e = pack4(32'h7FFF, 0, 0, 0);
    send_beat(pack4(32'h7FFF, 32'h8000, 0, 32'hFFFF), 2'b01, 16'd0);
    settle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL relu_early_valid: got %b expected 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL relu_latency: got out_valid %b expected 1", out_valid); end
    checks++; if (out_data !== e) begin errors++; $display("FAIL relu_data: got %h expected %h", out_data, e); end
    tick();
    exp_cnt += 2;
    checks++; if (zero_cnt !== CW'(exp_cnt)) begin errors++; $display("FAIL relu_zero_cnt: got %0d expected %0d", zero_cnt, exp_cnt); end
  endtask

  task automatic test_leaky_clip();
    logic [CH*DW-1:0] e_leak, e_clip;
    e_leak = pack4(-1, -1, -3, 100);
    e_clip = pack4(0, 3, 6, 6);
    in_valid = 1'b1; in_data = pack4(-8, -1, -17, 100); in_mode = 2'b10; clip_val = 16'd6;
    tick();
    in_data = pack4(-5, 3, 9, 6); in_mode = 2'b11;
    tick();
    in_valid = 1'b0;
    settle();
    checks++; if (out_valid !== 1'b1 || out_data !== e_leak) begin errors++; $display("FAIL leaky_data: got %b/%h expected 1/%h", out_valid, out_data, e_leak); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== e_clip) begin errors++; $display("FAIL clip_data: got %b/%h expected 1/%h", out_valid, out_data, e_clip); end
    tick();
    exp_cnt += 1;
    checks++; if (zero_cnt !== CW'(exp_cnt)) begin errors++; $display("FAIL leaky_clip_zero_cnt: got %0d expected %0d", zero_cnt, exp_cnt); end
  endtask

  task automatic test_mode_alternate();
    int k;
    logic [CH*DW-1:0] e;
    k = 0;
    clip_val = 16'd0;
    for (int s = 0; s < 8; s++) begin
      in_valid = (s < 4);
      in_data  = pack4(-2, -2, -2, -2);
      in_mode  = (s % 2 == 0) ? 2'b01 : 2'b00;
      settle();
      if (out_valid && out_ready) begin
        e = (k % 2 == 0) ? '0 : pack4(-2, -2, -2, -2);
        checks++; if (out_data !== e) begin errors++; $display("FAIL alt_mode_beat%0d: got %h expected %h", k, out_data, e); end
        k++;
      end
      tick();
    end
    in_valid = 1'b0;
    exp_cnt += 8;
    checks++; if (k != 4) begin errors++; $display("FAIL alt_mode_count: got %0d beats expected 4", k); end
    checks++; if (zero_cnt !== CW'(exp_cnt)) begin errors++; $display("FAIL alt_mode_zero_cnt: got %0d expected %0d", zero_cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [CH*DW-1:0] beats[4];
    logic [CH*DW-1:0] prev_d, e;
    int b, got, stall_left, stall_seen;
    bit seen, prev_st;
    for (int i = 0; i < 4; i++) beats[i] = rand_beat();
    b = 0; got = 0; stall_left = 0; stall_seen = 0; seen = 0; prev_st = 0; prev_d = '0;
    clip_val = 16'd50;
    q_data.delete(); q_z.delete();
    for (int cyc = 0; cyc < 20; cyc++) begin
      in_valid = (b < 4);
      if (b < 4) begin in_data = beats[b]; in_mode = 2'(b); end
      if (out_valid && !seen) begin seen = 1; stall_left = 3; end
      out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      settle();
      if (out_valid && !out_ready) begin
        stall_seen++;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
        if (prev_st) begin
          checks++; if (out_data !== prev_d) begin errors++; $display("FAIL stall_data_stable: got %h expected %h", out_data, prev_d); end
        end
      end
      prev_st = out_valid && !out_ready;
      prev_d  = out_data;
      if (in_valid && in_ready) begin
        q_data.push_back(ref_beat(in_data, in_mode, clip_val));
        q_z.push_back(ref_zeros(in_data, in_mode, clip_val));
        b++;
      end
      if (out_valid && out_ready) begin
        if (q_data.size() == 0) begin
          checks++; errors++; $display("FAIL b2b_extra_beat: got %h expected none", out_data);
        end else begin
          e = q_data.pop_front();
          exp_cnt += q_z.pop_front();
          checks++; if (out_data !== e) begin errors++; $display("FAIL b2b_beat%0d: got %h expected %h", got, out_data, e); end
          got++;
        end
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got != 4 || b != 4 || stall_seen != 3) begin errors++; $display("FAIL b2b_counts: got out %0d in %0d stalls %0d expected 4 4 3", got, b, stall_seen); end
    checks++; if (zero_cnt !== CW'(exp_cnt)) begin errors++; $display("FAIL b2b_zero_cnt: got %0d expected %0d", zero_cnt, exp_cnt); end
  endtask

  task automatic test_random();
    logic [CH*DW-1:0] e;
    bit pending;
    pending = 0;
    q_data.delete(); q_z.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!pending) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = rand_beat();
        in_mode  = 2'($urandom);
        clip_val = rand_clip();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      clr_stats = ($urandom_range(0, 39) == 0);
      settle();
      checks++; if (zero_cnt !== CW'(exp_cnt)) begin errors++; $display("FAIL rand_zero_cnt: got %0d expected %0d", zero_cnt, exp_cnt); end
      if (in_valid && in_ready) begin
        q_data.push_back(ref_beat(in_data, in_mode, clip_val));
        q_z.push_back(ref_zeros(in_data, in_mode, clip_val));
      end
      pending = in_valid && !in_ready;
      if (out_valid && out_ready) begin
        if (q_data.size() == 0) begin
          checks++; errors++; $display("FAIL rand_extra_beat: got %h expected none", out_data);
        end else begin
          e = q_data.pop_front();
          if (!clr_stats) exp_cnt += q_z.pop_front(); else void'(q_z.pop_front());
          checks++; if (out_data !== e) begin errors++; $display("FAIL rand_data: got %h expected %h", out_data, e); end
        end
      end
      if (clr_stats) exp_cnt = 0;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1; clr_stats = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      settle();
      if (out_valid) begin
        if (q_data.size() == 0) begin
          checks++; errors++; $display("FAIL rand_drain_extra: got %h expected none", out_data);
        end else begin
          e = q_data.pop_front();
          exp_cnt += q_z.pop_front();
          checks++; if (out_data !== e) begin errors++; $display("FAIL rand_drain_data: got %h expected %h", out_data, e); end
        end
      end
      tick();
    end
    checks++; if (q_data.size() != 0) begin errors++; $display("FAIL rand_lost_beats: got %0d pending expected 0", q_data.size()); end
    checks++; if (zero_cnt !== CW'(exp_cnt)) begin errors++; $display("FAIL rand_final_zero_cnt: got %0d expected %0d", zero_cnt, exp_cnt); end
  endtask

  task automatic test_saturate();
    logic [CH*DW-1:0] neg4, two, e;
    neg4 = pack4(-1, -100, -32768, -7);
    two  = pack4(-1, 5, -3, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    exp_cnt = 0; out_ready = 1'b1; clr_stats = 1'b0;
    repeat (3) send_beat(neg4, 2'b01, 16'd0);
    send_beat(two, 2'b01, 16'd0);
    repeat (3) tick();
    exp_cnt = 14;
    checks++; if (s_zero_cnt !== 4'd14) begin errors++; $display("FAIL sat_preload: got %0d expected 14", s_zero_cnt); end
    checks++; if (zero_cnt !== CW'(exp_cnt)) begin errors++; $display("FAIL sat_wide_preload: got %0d expected %0d", zero_cnt, exp_cnt); end
    send_beat(neg4, 2'b01, 16'd0);
    repeat (3) tick();
    exp_cnt += 4;
    checks++; if (s_zero_cnt !== 4'hF) begin errors++; $display("FAIL sat_reach_max: got %0d expected 15", s_zero_cnt); end
    checks++; if (zero_cnt !== CW'(exp_cnt)) begin errors++; $display("FAIL sat_wide_count: got %0d expected %0d", zero_cnt, exp_cnt); end
    send_beat(neg4, 2'b01, 16'd0);
    repeat (3) tick();
    checks++; if (s_zero_cnt !== 4'hF) begin errors++; $display("FAIL sat_hold_max: got %0d expected 15", s_zero_cnt); end
    send_beat(neg4, 2'b01, 16'd0);
    tick();
    e = '0;
    checks++; if (s_out_valid !== 1'b1 || out_valid !== 1'b1 || s_out_data !== e) begin errors++; $display("FAIL clr_pre_handshake: got %b/%b/%h expected 1/1/%h", s_out_valid, out_valid, s_out_data, e); end
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    exp_cnt = 0;
    checks++; if (zero_cnt !== '0 || s_zero_cnt !== '0) begin errors++; $display("FAIL clr_priority: got %0d/%0d expected 0/0", zero_cnt, s_zero_cnt); end
  endtask

  task automatic test_reset_midstream();
    logic [CH*DW-1:0] neg4;
    neg4 = pack4(-1, -2, -3, -4);
    out_ready = 1'b1;
    send_beat(neg4, 2'b01, 16'd0);
    in_valid = 1'b1; in_data = neg4; in_mode = 2'b11;
    tick();
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    settle();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
    for (int s = 0; s < 4; s++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid%0d: got %b expected 0", s, out_valid); end
      tick();
    end
    checks++; if (zero_cnt !== '0) begin errors++; $display("FAIL midrst_zero_cnt: got %0d expected 0", zero_cnt); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_stats = 1'b0;
    in_mode = 2'b00; in_data = '0; clip_val = '0;
    test_reset();
    test_relu();
    test_leaky_clip();
    test_mode_alternate();
    test_back_to_back();
    test_random();
    test_saturate();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
